// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream input and instruction-memory write port of the loader.
interface imem_loader_if #(parameter int ADDR_WIDTH = 8);
  logic [7:0] i_byte;
  logic i_byte_valid;
  logic o_byte_ready;
  logic o_imem_we;
  logic [ADDR_WIDTH-1:0] o_imem_addr;
  logic [31:0] o_imem_data;
  modport master (input i_byte, i_byte_valid, output o_byte_ready, o_imem_we, o_imem_addr, o_imem_data);
  modport slave (output i_byte, i_byte_valid, input o_byte_ready, o_imem_we, o_imem_addr, o_imem_data);
endinterface

// File: rtl/imem_loader.sv
// imem_loader: boot loader assembling big-endian words into instruction memory, then running the core to halt.
// LOADER_CHECKSUM_EN adds a trailing XOR checksum byte after the halt word.
module imem_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic clk,
  input  logic reset,
  imem_loader_if.master bus,
  output logic o_core_reset,
  input  logic i_core_halt,
  input  logic i_restart,
  output logic [2:0] o_state,
  output logic [ADDR_WIDTH:0] o_loaded_words,
  output logic [31:0] o_cycle_count,
  output logic o_overflow,
  output logic o_cksum_err
);
  typedef enum logic [2:0] {IDLE = 3'd0, LOAD = 3'd1, RUN = 3'd2, DONE = 3'd3, CHECK = 3'd4} state_t;
  state_t state_q, state_d;
  logic [1:0] lane_q, lane_d;
  logic [23:0] word_q, word_d;
  logic [ADDR_WIDTH:0] cnt_q, cnt_d;
  logic [31:0] cyc_q, cyc_d;
  logic core_rst_q, core_rst_d, ovf_q, ovf_d, err_q, err_d, we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic ready, take;
  logic [31:0] word;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;
`endif
  always_comb begin
    ready = (state_q == IDLE) || (state_q == LOAD) || (state_q == CHECK);
    take = ready && bus.i_byte_valid;
    word = {word_q, bus.i_byte};
    state_d = state_q;
    lane_d = lane_q;
    word_d = word_q;
    cnt_d = cnt_q;
    cyc_d = cyc_q;
    core_rst_d = core_rst_q;
    ovf_d = ovf_q;
    err_d = err_q;
    we_d = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
`ifdef LOADER_CHECKSUM_EN
    sum_d = sum_q;
    if (take && state_q != CHECK) sum_d = sum_q ^ bus.i_byte;
    if (take && state_q == CHECK) begin
      state_d = (bus.i_byte == sum_q) ? RUN : DONE;
      err_d = bus.i_byte != sum_q;
    end
`endif
    if (take && state_q != CHECK) begin
      lane_d = lane_q + 2'd1;
      word_d = word[23:0];
      state_d = LOAD;
      if (lane_q == 2'd3) begin
        if (cnt_q[ADDR_WIDTH]) begin
          ovf_d = 1'b1;
          state_d = DONE;
        end else begin
          we_d = 1'b1;
          addr_d = cnt_q[ADDR_WIDTH-1:0];
          data_d = word;
          cnt_d = cnt_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
`ifdef LOADER_CHECKSUM_EN
          if (word == HALT_WORD) state_d = CHECK;
`else
          if (word == HALT_WORD) state_d = RUN;
`endif
        end
      end
    end
    // the first RUN cycle overlaps the halt-word write, so the core leaves reset one edge later
    if (state_q == RUN) begin
      if (core_rst_q) core_rst_d = 1'b0;
      else if (i_core_halt) state_d = DONE;
      else if (cyc_q != 32'hFFFF_FFFF) cyc_d = cyc_q + 32'd1;
    end
    if (state_q == DONE && i_restart) begin
      state_d = IDLE;
      lane_d = 2'd0;
      cnt_d = '0;
      cyc_d = '0;
      core_rst_d = 1'b1;
      ovf_d = 1'b0;
      err_d = 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_d = '0;
`endif
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      lane_q <= '0;
      word_q <= '0;
      cnt_q <= '0;
      cyc_q <= '0;
      core_rst_q <= 1'b1;
      ovf_q <= 1'b0;
      err_q <= 1'b0;
      we_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      lane_q <= lane_d;
      word_q <= word_d;
      cnt_q <= cnt_d;
      cyc_q <= cyc_d;
      core_rst_q <= core_rst_d;
      ovf_q <= ovf_d;
      err_q <= err_d;
      we_q <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q <= sum_d;
`endif
    end
  end
  assign bus.o_byte_ready = ready;
  assign bus.o_imem_we = we_q;
  assign bus.o_imem_addr = addr_q;
  assign bus.o_imem_data = data_q;
  assign o_core_reset = core_rst_q;
  assign o_state = state_q;
  assign o_loaded_words = cnt_q;
  assign o_cycle_count = cyc_q;
  assign o_overflow = ovf_q;
  assign o_cksum_err = err_q;
endmodule
